// File: rtl/instr_prefetch_unit_pkg.sv
// rtl/instr_prefetch_unit_pkg.sv - shared constants, fetch state encoding and helpers for the prefetch unit
package instr_prefetch_unit_pkg;

  localparam int IPU_ADDR_W  = 8;
  localparam int IPU_INSTR_W = 16;

  localparam logic [IPU_ADDR_W-1:0] IPU_RESET_PC = 8'h00;

  // Opcode field of a fetched instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [IPU_INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// rtl/instr_prefetch_unit_if.sv - instruction memory req/ack bus and decoded-side valid/ready stream
interface instr_prefetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/instr_prefetch_unit_fetch_fifo.sv
// rtl/instr_prefetch_unit_fetch_fifo.sv - small FIFO holding {instruction, pc} pairs with synchronous flush
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Flush wins over push/pop so a redirect can never leave stale entries behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// rtl/instr_prefetch_unit.sv - fetch stage: owns the PC, issues one-outstanding memory reads, buffers results
module instr_prefetch_unit
  import instr_prefetch_unit_pkg::*;
#(
  parameter  int                DEPTH    = 4,
  parameter  int                ADDR_W   = IPU_ADDR_W,
  parameter  int                INSTR_W  = IPU_INSTR_W,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IPU_RESET_PC),
  localparam int                CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_prefetch_unit_if.master bus,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  halt,
  output logic [CNT_W-1:0]      fifo_count
);

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] fetch_pc_q;

  logic                      xfer;
  logic                      push;
  logic                      pop;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [CNT_W-1:0]          fifo_cnt;
  logic [ADDR_W+INSTR_W-1:0] fifo_head;
  logic                      credit_next;
  logic [ADDR_W-1:0]         next_addr;

  assign xfer      = mem_req_q && bus.mem_ack;
  assign next_addr = mem_addr_q + 1'b1;

  // Credit for another request after this ack: the pushed entry plus the new outstanding one
  // must both fit; a same-cycle pop is deliberately not counted.
  assign credit_next = (fifo_cnt < CNT_W'(DEPTH - 1));

  assign push = xfer && (state_q == REQ) && !redirect;
  assign pop  = bus.instr_ready && !redirect;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({bus.mem_rdata, mem_addr_q}),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr_data  = fifo_head[ADDR_W+INSTR_W-1:ADDR_W];
  assign bus.instr_pc    = fifo_head[ADDR_W-1:0];
  assign fifo_count      = fifo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else if (redirect) begin
      // An in-flight read cannot be cancelled on the bus; it is drained in DROP instead
      fetch_pc_q <= redirect_pc;
      case (state_q)
        REQ, DROP: begin
          if (xfer) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else begin
            state_q <= DROP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          // With nothing outstanding, credit is simply a non-full FIFO
          if (!fifo_full && !halt) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        REQ: begin
          if (xfer) begin
            fetch_pc_q <= next_addr;
            mem_addr_q <= next_addr;
            if (!(credit_next && !halt)) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (xfer) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_q && !bus.mem_ack) |=> (mem_req_q && $stable(mem_addr_q)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb/tb_instr_prefetch_unit.sv - directed bench for instr_prefetch_unit with a variable-latency memory model
module tb_instr_prefetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic [2:0] fifo_count;

  int lat;
  int wait_cnt;
  int xfers;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_prefetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  instr_prefetch_unit #(
    .DEPTH    (4),
    .ADDR_W   (8),
    .INSTR_W  (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .fifo_count  (fifo_count)
  );

  // Memory: word at address A is 16'h1000 + A, ack after lat wait cycles (lat=0 -> same cycle)
  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= lat);
  assign bus.mem_rdata = 16'h1000 + {8'h00, bus.mem_addr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      xfers    <= 0;
    end else begin
      if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
      else                             wait_cnt <= wait_cnt + 1;
      if (bus.mem_req && bus.mem_ack) xfers <= xfers + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, bus.instr_valid, 1);
    chk({tag, "_pc"}, bus.instr_pc, pc);
    chk({tag, "_data"}, bus.instr_data, 16'h1000 + {8'h00, pc});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] epc;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    halt = 1'b0;
    bus.instr_ready = 1'b1;
    lat = 0;

    // Reset values
    tick(); tick();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 8'h00);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", bus.instr_data, 0);
    chk("rst_pc", bus.instr_pc, 0);

    // Zero-wait streaming, one instruction per cycle
    rst_n = 1'b1;
    tick();
    chk("s1_req0", bus.mem_req, 1);
    chk("s1_addr0", bus.mem_addr, 8'h00);
    chk("s1_valid0", bus.instr_valid, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_head($sformatf("s1_h%0d", k), k[7:0]);
      chk($sformatf("s1_addr%0d", k + 1), bus.mem_addr, k + 1);
    end

    // Backpressure: exactly four fetches, then drain in order and resume at 04
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("s2_req_stop", bus.mem_req, 0);
    chk("s2_count_full", fifo_count, 4);
    chk("s2_xfers", xfers, 4);
    chk_head("s2_h0", 8'h00);
    tick();
    chk("s2_req_stop2", bus.mem_req, 0);
    bus.instr_ready = 1'b1;
    tick();
    chk_head("s2_h1", 8'h01);
    chk("s2_count3", fifo_count, 3);
    chk("s2_credit_lag", bus.mem_req, 0);
    tick();
    chk_head("s2_h2", 8'h02);
    chk("s2_resume_req", bus.mem_req, 1);
    chk("s2_resume_addr", bus.mem_addr, 8'h04);
    for (int k = 3; k < 6; k++) begin
      tick();
      chk_head($sformatf("s2_h%0d", k), k[7:0]);
    end

    // Redirect during a slow read: request held, its data dropped, refetch at 40
    lat = 3;
    do_reset();
    tick(); tick();
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    chk("s3_hold_req", bus.mem_req, 1);
    chk("s3_hold_addr", bus.mem_addr, 8'h00);
    tick();
    chk("s3_hold_addr2", bus.mem_addr, 8'h00);
    chk("s3_valid_wait", bus.instr_valid, 0);
    tick();
    chk("s3_drop_done", bus.mem_req, 0);
    chk("s3_drop_valid", bus.instr_valid, 0);
    tick();
    chk("s3_req40", bus.mem_req, 1);
    chk("s3_addr40", bus.mem_addr, 8'h40);
    repeat (3) tick();
    chk("s3_valid_pre", bus.instr_valid, 0);
    tick();
    chk_head("s3_h40", 8'h40);

    // Redirect coinciding with the ack of 05 while 03 and 04 are buffered
    lat = 0;
    halt = 1'b1;
    bus.instr_ready = 1'b0;
    do_reset();
    tick();
    chk("s4_halt_idle", bus.mem_req, 0);
    redirect = 1'b1;
    redirect_pc = 8'h03;
    tick();
    redirect = 1'b0;
    halt = 1'b0;
    tick();
    chk("s4_addr03", bus.mem_addr, 8'h03);
    tick(); tick();
    chk("s4_count2", fifo_count, 2);
    chk_head("s4_h03", 8'h03);
    chk("s4_addr05", bus.mem_addr, 8'h05);
    redirect = 1'b1;
    redirect_pc = 8'h80;
    tick();
    redirect = 1'b0;
    bus.instr_ready = 1'b1;
    chk("s4_flush_valid", bus.instr_valid, 0);
    chk("s4_flush_count", fifo_count, 0);
    chk("s4_flush_req", bus.mem_req, 0);
    tick();
    chk("s4_addr80", bus.mem_addr, 8'h80);
    tick();
    chk_head("s4_h80", 8'h80);

    // PC wrap FE -> FF -> 00 -> 01
    halt = 1'b1;
    do_reset();
    tick();
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    halt = 1'b0;
    tick();
    chk("s5_addrFE", bus.mem_addr, 8'hFE);
    for (int k = 0; k < 4; k++) begin
      tick();
      epc = 8'hFE + k[7:0];
      chk_head($sformatf("s5_h%0d", k), epc);
    end

    // Halt with a read outstanding, then resume, then asynchronous reset mid-request
    lat = 2;
    do_reset();
    tick();
    chk("s6_req0", bus.mem_req, 1);
    halt = 1'b1;
    tick(); tick();
    chk("s6_wait_req", bus.mem_req, 1);
    tick();
    chk_head("s6_h00", 8'h00);
    chk("s6_halt_noreq", bus.mem_req, 0);
    tick();
    chk("s6_halt_noreq2", bus.mem_req, 0);
    chk("s6_xfers", xfers, 1);
    tick();
    halt = 1'b0;
    tick();
    chk("s6_resume_req", bus.mem_req, 1);
    chk("s6_resume_addr", bus.mem_addr, 8'h01);
    repeat (3) tick();
    chk_head("s6_h01", 8'h01);
    chk("s6_mid_req", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_arst_req", bus.mem_req, 0);
    chk("s6_arst_valid", bus.instr_valid, 0);
    chk("s6_arst_count", fifo_count, 0);
    chk("s6_arst_addr", bus.mem_addr, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Fetch stage that sits directly upstream of the decode/execute datapath: control_unit, register_file, alu.
- Owns the program counter and issues reads to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned 16-bit instructions in a small FIFO and presents them with their PC over a valid/ready interface.
- Execute stage uses a redirect input for taken branches; the halt input comes from Continue = 0.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 8, PC / instruction address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  read address; stable while mem_req=1.
- mem_ack  input  1  read complete; mem_rdata valid this cycle. May be high in the same cycle mem_req rises.
- mem_rdata  input  INSTR_W  read data.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  consumer accepts head.
- instr_data  output  INSTR_W  head instruction.
- instr_pc  output  ADDR_W  address the head was fetched from.
- redirect  input  1  taken branch; flush and refetch.
- redirect_pc  input  ADDR_W  new fetch address.
- halt  input  1  suppress new requests.
- fifo_count  output  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async assert, sync release):
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, fifo_count=0.
  - instr_data/instr_pc = 0; fetch_pc=RESET_PC; state=IDLE.
- All outputs are registered except instr_valid/instr_data/instr_pc, which are the FIFO head.
- Handshake:
  - Transfer occurs on a cycle with mem_req & mem_ack.
  - At most one outstanding request.
  - mem_req and mem_addr are held until ack.
- Credit rule: a request issues only if fifo_count + outstanding < DEPTH and halt=0. A pop in the same cycle does not free credit until the next cycle.
- State machine:
  - IDLE: if credit and !halt -> REQ; mem_req=1, mem_addr=fetch_pc.
  - REQ, on ack: push {mem_rdata, mem_addr}; fetch_pc = mem_addr+1, wrapping 8'hFF -> 8'h00. If credit remains and !halt, stay REQ with the new address (back-to-back, one fetch per cycle with zero-wait memory); else go to IDLE.
  - DROP: outstanding request is being discarded. Hold mem_req until ack, discard data, then go to IDLE.
- Redirect (highest priority):
  - FIFO is emptied the same edge; instr_valid=0 the next cycle.
  - fetch_pc=redirect_pc.
  - From IDLE -> IDLE; the next cycle may issue to redirect_pc.
  - From REQ without ack -> DROP.
  - From REQ with ack in the same cycle -> data discarded -> IDLE.
  - From DROP -> stay in DROP; the target is updated to the latest redirect_pc.
- Simultaneous events:
  - redirect & instr_ready: pop ignored.
  - push & pop on the same edge: count unchanged.
  - halt while REQ: outstanding request completes and is pushed; no further requests.
- Latency: instruction at address A becomes instr_valid the cycle after its ack.
- FIFO ordering is strict; a pop happens only when instr_valid & instr_ready.
- Reset mid-request: everything returns to reset values immediately. Memory must tolerate a dropped request.

Decomposition:
- cpu_pkg:
  - ADDR_W and INSTR_W constants.
  - Opcode field position [15:12].
  - RESET_PC.
  - Fetch state enum {IDLE, REQ, DROP}.
- Sub-module fetch_fifo (DEPTH, width ADDR_W+INSTR_W):
  - Synchronous push/pop and flush.
  - count, empty and full outputs.
  - Async active-low reset.

Test Plan:
- Zero-wait memory (ack = req), instr_ready=1, memory holds word = 16'h1000+addr -> after reset, addresses 00,01,02... on consecutive cycles. Output pairs (pc, data) = (00,1000), (01,1001)..., one per cycle, first valid 2 cycles after rst_n release.
- instr_ready=0, zero-wait memory -> exactly 4 requests (00..03), then mem_req=0, fifo_count=4. Release ready -> FIFO drains in order, fetch resumes at 04.
- Ack delayed 3 cycles, redirect to 8'h40 in the second wait cycle -> mem_req/mem_addr held until ack, that data never appears. Next request addr=40, first output (40, 1040).
- Redirect in the same cycle as ack of addr 05, with FIFO holding 03 and 04 -> FIFO empty next cycle, 05 discarded, next output (redirect_pc, data).
- Start fetch_pc=FE via redirect -> outputs FE, FF, 00, 01 (wrap).
- halt=1 while a request is outstanding -> that instruction is delivered, no new mem_req. Deassert halt -> fetch continues at the next sequential address. Assert rst_n=0 mid-REQ -> mem_req=0 and instr_valid=0 immediately (asynchronously).
